inst_fetch_buffer: RTL and testbench

//  Decouples the AXI instruction-fetch front end from decode. Queues returned

---
 rtl/inst_fetch_buffer.sv | 102 ++++++++++
 tb/tb_inst_fetch_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: instruction queue between fetch bridge and decode; ports clk/rst, flushD/stallD, req_fire, rsp_*, can_req, validD/instrD/pcD/adelD; optional IFB_BYPASS_EN zero-latency path
module inst_fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushD,
  input  logic        stallD,
  input  logic        req_fire,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_instr,
  input  logic [31:0] rsp_pc,
  input  logic        rsp_adel,
  output logic        can_req,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        adelD
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, outstanding_q, outstanding_d, discard_q, discard_d;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] instr_d [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [31:0] pc_d [DEPTH];
  logic adel_q [DEPTH];
  logic adel_d [DEPTH];
  logic empty, rsp_ok, push, pop, wr_en;
  assign empty = count_q == '0;
  assign rsp_ok = rsp_valid && outstanding_q != '0;
  assign push = rsp_ok && discard_q == '0 && !flushD;
  assign pop = !empty && !stallD;
  assign can_req = !flushD && (32'(count_q) + 32'(outstanding_q) < DEPTH);
`ifdef IFB_BYPASS_EN
  logic byp;
  assign byp = empty && push;
  assign validD = !empty || byp;
  assign instrD = !empty ? instr_q[rd_ptr_q] : (byp && !rsp_adel) ? rsp_instr : '0;
  assign pcD = !empty ? pc_q[rd_ptr_q] : byp ? rsp_pc : '0;
  assign adelD = !empty ? adel_q[rd_ptr_q] : byp && rsp_adel;
  // a bypassed response consumed by decode never touches the queue
  assign wr_en = push && !(byp && !stallD);
`else
  assign validD = !empty;
  assign instrD = empty ? '0 : instr_q[rd_ptr_q];
  assign pcD = empty ? '0 : pc_q[rd_ptr_q];
  assign adelD = !empty && adel_q[rd_ptr_q];
  assign wr_en = push;
`endif
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    outstanding_d = outstanding_q;
    discard_d = discard_q;
    instr_d = instr_q;
    pc_d = pc_q;
    adel_d = adel_q;
    if (flushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d = '0;
      // every request still in flight after this edge must be dropped
      outstanding_d = outstanding_q - CW'(rsp_ok);
      discard_d = outstanding_q - CW'(rsp_ok);
    end else begin
      if (wr_en) begin
        instr_d[wr_ptr_q] = rsp_adel ? '0 : rsp_instr;
        pc_d[wr_ptr_q] = rsp_pc;
        adel_d[wr_ptr_q] = rsp_adel;
      end
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d = count_q + CW'(wr_en) - CW'(pop);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
      discard_d = (rsp_ok && discard_q != '0) ? discard_q - CW'(1) : discard_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      outstanding_q <= '0;
      discard_q <= '0;
      instr_q <= '{default: '0};
      pc_q <= '{default: '0};
      adel_q <= '{default: 1'b0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      outstanding_q <= outstanding_d;
      discard_q <= discard_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      adel_q <= adel_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed vector table plus randomized run against a queue-based reference model
module tb_inst_fetch_buffer;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, flushD = 0, stallD = 0, req_fire = 0, rsp_valid = 0, rsp_adel = 0;
  logic [31:0] rsp_instr = 0, rsp_pc = 0;
  logic can_req, validD, adelD;
  logic [31:0] instrD, pcD;
  int checks = 0, failures = 0;
  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD), .req_fire(req_fire),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_adel(rsp_adel),
    .can_req(can_req), .validD(validD), .instrD(instrD), .pcD(pcD), .adelD(adelD)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic f, s, r, v;
    logic [31:0] i, p;
    logic a;
    logic ec, ev;
    logic [31:0] ei, ep;
    logic ea;
  } vec_t;
  typedef struct {
    logic [31:0] i, p;
    logic a;
  } ent_t;
  vec_t tbl[$];
  ent_t q[$];
  int m_out, m_disc;
  task automatic drive(input logic f, s, r, v, input logic [31:0] i, p, input logic a);
    flushD = f; stallD = s; req_fire = r; rsp_valid = v; rsp_instr = i; rsp_pc = p; rsp_adel = a;
  endtask
  task automatic check(input string name, input logic ec, ev, input logic [31:0] ei, ep, input logic ea);
    checks++;
    if ({can_req, validD, instrD, pcD, adelD} !== {ec, ev, ei, ep, ea}) begin
      failures++;
      $display("FAIL %s: got can_req=%b validD=%b instrD=%h pcD=%h adelD=%b, expected %b %b %h %h %b",
               name, can_req, validD, instrD, pcD, adelD, ec, ev, ei, ep, ea);
    end
  endtask
  task automatic addv(input logic f, s, r, v, input logic [31:0] i, p, input logic a,
                      input logic ec, ev, input logic [31:0] ei, ep, input logic ea);
    vec_t t;
    t.f = f; t.s = s; t.r = r; t.v = v; t.i = i; t.p = p; t.a = a;
    t.ec = ec; t.ev = ev; t.ei = ei; t.ep = ep; t.ea = ea;
    tbl.push_back(t);
  endtask
  initial begin
    // stream
    addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h24020001, 32'hBFC00000, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h24020001, 32'hBFC00000, 0);
    // backpressure
    addv(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 32'h00000011, 32'h100, 0, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 32'h00000022, 32'h104, 0, 0, 1, 32'h11, 32'h100, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h11, 32'h100, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 32'h100, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h22, 32'h104, 0);
    // address error
    addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 32'hFFFFFFFF, 32'h80000001, 1, 1, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h80000001, 1);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h80000001, 1);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // flush with two outstanding
    addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h11111111, 32'h200, 0, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h22222222, 32'h204, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h33333333, 32'h208, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h33333333, 32'h208, 0);
    // flush coincident with the only response
    addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(1, 0, 0, 1, 32'h55555555, 32'h20C, 0, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h44444444, 32'h210, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h44444444, 32'h210, 0);
    // flush with a queued entry
    addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 32'h66, 32'h214, 0, 1, 0, 0, 0, 0);
    addv(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h66, 32'h214, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // response with nothing outstanding is ignored
    addv(0, 0, 0, 1, 32'h77, 32'h218, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check("reset", 1, 0, 0, 0, 0);
    rst = 0;
`ifndef IFB_BYPASS_EN
    foreach (tbl[k]) begin
      drive(tbl[k].f, tbl[k].s, tbl[k].r, tbl[k].v, tbl[k].i, tbl[k].p, tbl[k].a);
      #1 check($sformatf("vec%0d", k), tbl[k].ec, tbl[k].ev, tbl[k].ei, tbl[k].ep, tbl[k].ea);
      @(posedge clk); #1;
    end
`endif
    // asynchronous reset while an entry is queued
    drive(0, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 1, 32'hABCD0001, 32'h300, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 0, 0);
    #1 check("prefill", 1, 1, 32'hABCD0001, 32'h300, 0);
    #2 rst = 1;
    #1 check("async_rst", 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 0;
    q.delete(); m_out = 0; m_disc = 0;
    for (int n = 0; n < 1500; n++) begin
      logic f, s, r, v, a, push, byp, ev, ec;
      logic [31:0] i, p;
      ent_t e, h;
      f = $urandom_range(0, 19) == 0;
      s = $urandom_range(0, 2) == 0;
      r = !f && (q.size() + m_out < DEPTH) && $urandom_range(0, 1) == 1;
      v = m_out > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 29) == 0;
      i = $urandom; p = $urandom; a = $urandom_range(0, 7) == 0;
      drive(f, s, r, v, i, p, a);
      push = v && m_out > 0 && m_disc == 0 && !f;
      e.i = a ? 32'h0 : i; e.p = p; e.a = a;
`ifdef IFB_BYPASS_EN
      byp = q.size() == 0 && push;
`else
      byp = 0;
`endif
      ec = !f && (q.size() + m_out < DEPTH);
      ev = q.size() > 0 || byp;
      h.i = 0; h.p = 0; h.a = 0;
      if (q.size() > 0) h = q[0]; else if (byp) h = e;
      #1 check($sformatf("rand%0d", n), ec, ev, h.i, h.p, h.a);
      @(posedge clk);
      if (f) begin
        q.delete();
        m_out = m_out - ((v && m_out > 0) ? 1 : 0);
        m_disc = m_out;
      end else begin
        if (v && m_out > 0 && m_disc > 0) m_disc--;
        m_out = m_out + (r ? 1 : 0) - ((v && m_out > 0) ? 1 : 0);
        if (!(byp && !s)) begin
          if (q.size() > 0 && !s) void'(q.pop_front());
          if (push) q.push_back(e);
        end
      end
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
